// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one registered ALU between two requesters.
//   req0 (execute pipeline) and req1 (address generation) each own a
//   valid/ready request channel and a valid/ready response channel.
//   One operation is in flight at a time: IDLE -> EXEC -> CAPTURE -> RESP.
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_reqN_* / o_reqN_ready request channel N (operands, opcode, shift amount)
//   o_respN_* / i_respN_ready response channel N (result and flags, held)
//   o_alu_* / i_alu_*       operand/control to the ALU, result/flags back
//   o_busy                  high whenever the arbiter is not idle
module alu_arbiter #(
    parameter int unsigned ALU_LATENCY = 1,
    parameter int unsigned FIRST_PRIO  = 0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req0_valid,
    output logic        o_req0_ready,
    input  logic [31:0] i_req0_operand_A,
    input  logic [31:0] i_req0_operand_B,
    input  logic [3:0]  i_req0_alu_control,
    input  logic [4:0]  i_req0_shmant,
    input  logic        i_req1_valid,
    output logic        o_req1_ready,
    input  logic [31:0] i_req1_operand_A,
    input  logic [31:0] i_req1_operand_B,
    input  logic [3:0]  i_req1_alu_control,
    input  logic [4:0]  i_req1_shmant,
    output logic        o_resp0_valid,
    input  logic        i_resp0_ready,
    output logic [31:0] o_resp0_result,
    output logic        o_resp0_overflow,
    output logic        o_resp0_zero,
    output logic        o_resp0_less,
    output logic        o_resp1_valid,
    input  logic        i_resp1_ready,
    output logic [31:0] o_resp1_result,
    output logic        o_resp1_overflow,
    output logic        o_resp1_zero,
    output logic        o_resp1_less,
    output logic [31:0] o_alu_operand_A,
    output logic [31:0] o_alu_operand_B,
    output logic [3:0]  o_alu_control,
    output logic [4:0]  o_alu_shmant,
    input  logic [31:0] i_alu_result,
    input  logic        i_alu_overflow,
    input  logic        i_alu_zero,
    input  logic        i_alu_less,
    output logic        o_busy
);

    localparam int unsigned CNT_W = 3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_CAPT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last_grant;
    logic             r_owner;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_accept;
    logic             w_resp_hs;

    // On contention the requester that was not served last wins
    assign w_gnt0 = i_req0_valid & (~i_req1_valid | r_last_grant);
    assign w_gnt1 = i_req1_valid & (~i_req0_valid | ~r_last_grant);

    assign o_req0_ready = (r_state == S_IDLE) & w_gnt0;
    assign o_req1_ready = (r_state == S_IDLE) & w_gnt1;
    assign w_accept     = o_req0_ready | o_req1_ready;

    // Only the owner ever has a valid response, so OR-ing both is safe
    assign w_resp_hs = (o_resp0_valid & i_resp0_ready) | (o_resp1_valid & i_resp1_ready);

    assign o_busy = (r_state != S_IDLE);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_EXEC;
            S_EXEC: if (r_cnt == CNT_W'(1)) w_state_nxt = S_CAPT;
            S_CAPT: w_state_nxt = S_RESP;
            S_RESP: if (w_resp_hs) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Issue registers double as the ALU drive; they only change on a new issue
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_last_grant     <= (FIRST_PRIO == 0) ? 1'b1 : 1'b0;
            r_owner          <= 1'b0;
            r_cnt            <= '0;
            o_alu_operand_A  <= '0;
            o_alu_operand_B  <= '0;
            o_alu_control    <= '0;
            o_alu_shmant     <= '0;
            o_resp0_valid    <= 1'b0;
            o_resp0_result   <= '0;
            o_resp0_overflow <= 1'b0;
            o_resp0_zero     <= 1'b0;
            o_resp0_less     <= 1'b0;
            o_resp1_valid    <= 1'b0;
            o_resp1_result   <= '0;
            o_resp1_overflow <= 1'b0;
            o_resp1_zero     <= 1'b0;
            o_resp1_less     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_owner      <= w_gnt1;
                        r_last_grant <= w_gnt1;
                        r_cnt        <= CNT_W'(ALU_LATENCY);
                        if (w_gnt1) begin
                            o_alu_operand_A <= i_req1_operand_A;
                            o_alu_operand_B <= i_req1_operand_B;
                            o_alu_control   <= i_req1_alu_control;
                            o_alu_shmant    <= i_req1_shmant;
                        end else begin
                            o_alu_operand_A <= i_req0_operand_A;
                            o_alu_operand_B <= i_req0_operand_B;
                            o_alu_control   <= i_req0_alu_control;
                            o_alu_shmant    <= i_req0_shmant;
                        end
                    end
                end
                S_EXEC: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                S_CAPT: begin
                    if (r_owner) begin
                        o_resp1_valid    <= 1'b1;
                        o_resp1_result   <= i_alu_result;
                        o_resp1_overflow <= i_alu_overflow;
                        o_resp1_zero     <= i_alu_zero;
                        o_resp1_less     <= i_alu_less;
                    end else begin
                        o_resp0_valid    <= 1'b1;
                        o_resp0_result   <= i_alu_result;
                        o_resp0_overflow <= i_alu_overflow;
                        o_resp0_zero     <= i_alu_zero;
                        o_resp0_less     <= i_alu_less;
                    end
                end
                S_RESP: begin
                    if (w_resp_hs) begin
                        o_resp0_valid <= 1'b0;
                        o_resp1_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: two arbiter instances (latency 1 / first-prio 0 and
// latency 3 / first-prio 1), each with a behavioural ALU, driven from one
// stimulus process and checked by a per-instance transaction-level monitor.
module tb_alu_arbiter;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctl;
        logic [4:0]  sh;
    } op_t;

    typedef struct packed {
        logic [31:0] r;
        logic        ov;
        logic        z;
        logic        lt;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic rst     [2];
    logic rq_v    [2][2];
    op_t  rq_op   [2][2];
    logic rs_r    [2][2];
    logic rq_rdy  [2][2];
    logic busy_o  [2];
    logic hs      [2][2];
    int   wcnt    [2][2];
    bit   hold    [2][2];
    bit   rmode   [2];
    op_t  pq      [4][$];
    int   gl0[$];
    int   gl1[$];

    task automatic chk(input int ln, input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL lane%0d %s: got 0x%0h expected 0x%0h at %0t", ln, nm, act, exp, $time);
        end
    endtask

    // Reference ALU behaviour: plain arithmetic on the opcode table
    function automatic res_t alu_f(input op_t o);
        res_t x;
        x = '0;
        case (o.ctl)
            4'b0010: begin
                x.r  = o.a + o.b;
                x.ov = (o.a[31] == o.b[31]) && (x.r[31] != o.a[31]);
            end
            4'b0011: begin
                x.r  = o.a - o.b;
                x.ov = (o.a[31] != o.b[31]) && (x.r[31] != o.a[31]);
                x.lt = $signed(o.a) < $signed(o.b);
            end
            4'b0100: x.r = o.a & o.b;
            4'b0101: x.r = o.a | o.b;
            4'b0110: x.r = o.a ^ o.b;
            4'b0111: x.r = ~o.a;
            4'b1000: x.r = o.a << o.sh;
            4'b1001: x.r = o.a >> o.sh;
            4'b1010: x.r = ~(o.a | o.b);
            4'b1011: begin
                x.r  = o.a - o.b;
                x.lt = o.a < o.b;
            end
            4'b1100: x.r = o.a + o.b;
            default: x.r = '0;
        endcase
        x.z = (x.r == 32'd0);
        return x;
    endfunction

    function automatic op_t mk(input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] c, input logic [4:0] s);
        op_t o;
        o.a = a; o.b = b; o.ctl = c; o.sh = s;
        return o;
    endfunction

    function automatic op_t rnd_op();
        op_t o;
        logic [3:0] tab [12];
        tab = '{4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hF};
        o.a   = $urandom;
        o.b   = ($urandom_range(0, 3) == 0) ? o.a : $urandom;
        o.sh  = 5'($urandom);
        o.ctl = tab[$urandom_range(0, 11)];
        return o;
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_lane
        localparam int unsigned LAT = (k == 0) ? 1 : 3;
        localparam int unsigned FP  = (k == 0) ? 0 : 1;

        logic [31:0] alu_a, alu_b, alu_r;
        logic [3:0]  alu_c;
        logic [4:0]  alu_s;
        logic        alu_ov, alu_z, alu_lt;
        logic        rdy0, rdy1, rv0, rv1, bsy;
        logic [31:0] r0, r1;
        logic        ov0, z0, lt0, ov1, z1, lt1;
        res_t        pipe [LAT];

        alu_arbiter #(.ALU_LATENCY(LAT), .FIRST_PRIO(FP)) u_dut (
            .i_clk(clk), .i_reset(rst[k]),
            .i_req0_valid(rq_v[k][0]), .o_req0_ready(rdy0),
            .i_req0_operand_A(rq_op[k][0].a), .i_req0_operand_B(rq_op[k][0].b),
            .i_req0_alu_control(rq_op[k][0].ctl), .i_req0_shmant(rq_op[k][0].sh),
            .i_req1_valid(rq_v[k][1]), .o_req1_ready(rdy1),
            .i_req1_operand_A(rq_op[k][1].a), .i_req1_operand_B(rq_op[k][1].b),
            .i_req1_alu_control(rq_op[k][1].ctl), .i_req1_shmant(rq_op[k][1].sh),
            .o_resp0_valid(rv0), .i_resp0_ready(rs_r[k][0]), .o_resp0_result(r0),
            .o_resp0_overflow(ov0), .o_resp0_zero(z0), .o_resp0_less(lt0),
            .o_resp1_valid(rv1), .i_resp1_ready(rs_r[k][1]), .o_resp1_result(r1),
            .o_resp1_overflow(ov1), .o_resp1_zero(z1), .o_resp1_less(lt1),
            .o_alu_operand_A(alu_a), .o_alu_operand_B(alu_b),
            .o_alu_control(alu_c), .o_alu_shmant(alu_s),
            .i_alu_result(alu_r), .i_alu_overflow(alu_ov),
            .i_alu_zero(alu_z), .i_alu_less(alu_lt),
            .o_busy(bsy)
        );

        assign rq_rdy[k][0] = rdy0;
        assign rq_rdy[k][1] = rdy1;
        assign busy_o[k]    = bsy;

        // Registered ALU with LAT edges from inputs to result, sharing the reset
        always @(posedge clk) begin
            if (rst[k]) begin
                for (int i = 0; i < int'(LAT); i++) pipe[i] <= '0;
            end else begin
                pipe[0] <= alu_f({alu_a, alu_b, alu_c, alu_s});
                for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
            end
        end
        assign alu_r  = pipe[LAT-1].r;
        assign alu_ov = pipe[LAT-1].ov;
        assign alu_z  = pipe[LAT-1].z;
        assign alu_lt = pipe[LAT-1].lt;

        // Monitor: transaction-level model of grant order, timing and results
        initial begin : mon
            bit         idle, last, own, post_rst;
            int         cyc, acc, w;
            op_t        mop;
            res_t       e;
            res_t       eq0[$];
            res_t       eq1[$];
            logic [1:0] v, erdy, erv;
            idle = 1'b1; last = (FP == 0); own = 1'b0; post_rst = 1'b0;
            cyc = 0; acc = 0; mop = '0;
            forever begin
                @(negedge clk);
                cyc++;
                if (rst[k]) begin
                    eq0.delete(); eq1.delete();
                    idle = 1'b1; last = (FP == 0); post_rst = 1'b1;
                end else begin
                    if (post_rst) begin
                        chk(k, "reset_alu_out", {alu_a, alu_b, alu_c, alu_s}, '0);
                        chk(k, "reset_resp_data", {r0, ov0, z0, lt0, r1, ov1, z1, lt1}, '0);
                        post_rst = 1'b0;
                    end
                    v    = {rq_v[k][1], rq_v[k][0]};
                    erdy = 2'b00;
                    if (idle) erdy = (v == 2'b11) ? (last ? 2'b01 : 2'b10) : v;
                    chk(k, "req_ready", {rdy1, rdy0}, erdy);
                    chk(k, "busy", bsy, !idle);
                    erv = 2'b00;
                    if (!idle && cyc >= acc + int'(LAT) + 2) erv = own ? 2'b10 : 2'b01;
                    chk(k, "resp_valid", {rv1, rv0}, erv);
                    if (erv != 2'b00) begin
                        e = own ? eq1[0] : eq0[0];
                        if (own) chk(k, "resp1_data", {r1, ov1, z1, lt1}, e);
                        else     chk(k, "resp0_data", {r0, ov0, z0, lt0}, e);
                    end
                    if (!idle) chk(k, "alu_drive", {alu_a, alu_b, alu_c, alu_s}, mop);
                    if (erdy != 2'b00) begin
                        w    = int'(erdy[1]);
                        mop  = rq_op[k][w];
                        if (w == 1) eq1.push_back(alu_f(mop)); else eq0.push_back(alu_f(mop));
                        idle = 1'b0; own = erdy[1]; last = erdy[1]; acc = cyc;
                        if (k == 0) gl0.push_back(w); else gl1.push_back(w);
                    end else if (erv != 2'b00 && rs_r[k][own]) begin
                        if (own) void'(eq1.pop_front()); else void'(eq0.pop_front());
                        idle = 1'b1;
                    end
                end
            end
        end
    end

    // One clock of driver activity for both instances
    task automatic tick();
        @(negedge clk);
        for (int l = 0; l < 2; l++)
            for (int r = 0; r < 2; r++) hs[l][r] = rq_v[l][r] & rq_rdy[l][r];
        @(posedge clk);
        #1;
        for (int l = 0; l < 2; l++) begin
            for (int r = 0; r < 2; r++) begin
                if (hs[l][r]) begin
                    rq_v[l][r] = 1'b0;
                    wcnt[l][r] = 0;
                end else if (rq_v[l][r]) begin
                    wcnt[l][r]++;
                    if (wcnt[l][r] > 400) begin
                        n_chk++; n_fail++;
                        $display("FAIL lane%0d req%0d_wait_timeout: no ready after 400 cycles", l, r);
                        rq_v[l][r] = 1'b0;
                        wcnt[l][r] = 0;
                    end
                end
                if (!rq_v[l][r]) begin
                    if (pq[l*2+r].size() != 0) begin
                        rq_op[l][r] = pq[l*2+r].pop_front();
                        rq_v[l][r]  = 1'b1;
                    end else begin
                        rq_op[l][r] = rnd_op();
                    end
                end
                rs_r[l][r] = hold[l][r] ? 1'b0 : (rmode[l] ? 1'($urandom_range(0, 1)) : 1'b1);
            end
        end
    endtask

    task automatic wait_idle(input int l);
        int quiet, n;
        quiet = 0; n = 0;
        while (quiet < 3) begin
            tick();
            n++;
            if (pq[l*2].size() == 0 && pq[l*2+1].size() == 0 && !rq_v[l][0] && !rq_v[l][1] && !busy_o[l])
                quiet++;
            else
                quiet = 0;
            if (n > 3000) begin
                n_chk++; n_fail++;
                $display("FAIL lane%0d drain_timeout: still busy after 3000 cycles", l);
                break;
            end
        end
    endtask

    task automatic do_reset(input int l);
        rst[l] = 1'b1;
        tick();
        tick();
        rst[l] = 1'b0;
    endtask

    task automatic rand_phase(input int l, input int nops);
        rmode[l] = 1'b1;
        for (int i = 0; i < nops; i++) begin
            pq[l*2 + $urandom_range(0, 1)].push_back(rnd_op());
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_idle(l);
        rmode[l] = 1'b0;
    endtask

    initial begin
        int n, ord [4];
        ord = '{0, 1, 0, 1};
        for (int l = 0; l < 2; l++) begin
            rst[l] = 1'b1; rmode[l] = 1'b0;
            for (int r = 0; r < 2; r++) begin
                rq_v[l][r] = 1'b0; rq_op[l][r] = '0; rs_r[l][r] = 1'b0;
                hs[l][r] = 1'b0; wcnt[l][r] = 0; hold[l][r] = 1'b0;
            end
        end
        repeat (3) tick();
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Single ADD on req0
        pq[0].push_back(mk(32'd5, 32'd7, 4'b0010, 5'd0));
        wait_idle(0);

        // Simultaneous requests after reset, twice each: order 0,1,0,1
        do_reset(0);
        gl0.delete();
        pq[0].push_back(mk(32'd10, 32'd3, 4'b0011, 5'd0));
        pq[1].push_back(mk(32'hF0, 32'h0F, 4'b0100, 5'd0));
        pq[0].push_back(mk(32'd10, 32'd3, 4'b0011, 5'd0));
        pq[1].push_back(mk(32'hF0, 32'h0F, 4'b0100, 5'd0));
        wait_idle(0);
        chk(0, "grant_count", gl0.size(), 4);
        for (int i = 0; i < 4; i++) chk(0, "grant_order", (i < gl0.size()) ? gl0[i] : -1, ord[i]);

        // SLL on req1 with its response held while req0 waits
        hold[0][1] = 1'b1;
        pq[1].push_back(mk(32'd1, 32'd0, 4'b1000, 5'd4));
        repeat (4) tick();
        pq[0].push_back(mk(32'd2, 32'd2, 4'b0010, 5'd0));
        repeat (8) tick();
        hold[0][1] = 1'b0;
        wait_idle(0);

        // Signed SUB going negative
        pq[0].push_back(mk(32'd3, 32'd10, 4'b0011, 5'd0));
        wait_idle(0);

        // Reset during EXEC discards the op; a fresh contention grants req0
        pq[0].push_back(mk(32'h1234, 32'h1111, 4'b0010, 5'd0));
        n = 0;
        do begin
            tick();
            n++;
        end while (!hs[0][0] && n < 50);
        chk(0, "exec_reset_handshake", hs[0][0], 1'b1);
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        gl0.delete();
        pq[0].push_back(mk(32'h8000_0000, 32'h8000_0000, 4'b0010, 5'd0));
        pq[1].push_back(mk(32'hFFFF_FFFF, 32'd1, 4'b1100, 5'd0));
        wait_idle(0);
        chk(0, "post_reset_first_grant", (gl0.size() > 0) ? gl0[0] : -1, 0);

        rand_phase(0, 40);

        // Latency-3 instance: ADD 1+1, then first-prio contention, then random
        pq[2].push_back(mk(32'd1, 32'd1, 4'b0010, 5'd0));
        wait_idle(1);
        do_reset(1);
        gl1.delete();
        pq[2].push_back(mk(32'd9, 32'd9, 4'b1011, 5'd0));
        pq[3].push_back(mk(32'hFFFF_0000, 32'd0, 4'b1001, 5'd8));
        wait_idle(1);
        chk(1, "first_prio_grant", (gl1.size() > 0) ? gl1[0] : -1, 1);
        rand_phase(1, 20);

        wait_idle(0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
